// File: rtl/uart_pkg.sv
// Shared types and configuration helpers for the UART transmit framer.
package uart_pkg;

  // Framer states; the encoding is fixed so debug views stay stable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Configuration legality, evaluated at elaboration by the framer.
  function automatic bit data_bits_ok(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit stop_bits_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit parity_ok(input int p);
    return (p == PAR_NONE) || (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the word source and the framer.
// Handshake: a word moves when in_valid && in_ready are both high at a clk
// edge; in_ready is simply "register empty", and the source must keep
// in_data stable while in_valid is high and in_ready is low.
module uart_tx_hold
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 reset_pulse,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 take,
  output logic                 full,
  output logic [DATA_BITS-1:0] hold_data,
  output logic                 hold_par
);

  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 par_calc;

  // Parity bit that makes the ones count of data+parity odd or even.
  always_comb begin
    par_calc = 1'b0;
    if (PARITY == PAR_ODD) begin
      par_calc = ~(^in_data);
    end else if (PARITY == PAR_EVEN) begin
      par_calc = ^in_data;
    end
  end

  // Accept into the empty register, or release it when the framer takes it.
  // Both cannot happen together because take implies full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    par_d  = par_q;
    if (take) begin
      full_d = 1'b0;
    end else if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
      par_d  = par_calc;
    end
  end

  // Holding register flops.
  always_ff @(posedge clk) begin
    if (reset_pulse) begin
      full_q <= 1'b0;
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  // Registered status straight to the ports.
  always_comb begin
    in_ready  = ~full_q;
    full      = full_q;
    hold_data = data_q;
    hold_par  = par_q;
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB first, optional
// parity, 1 or 2 stop bits. All line changes happen on baud_tick cycles and
// appear on tx_out one cycle later. A queued word follows the last stop bit
// with no idle gap.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_pulse,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (!data_bits_ok(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be in 5..9");
  end
  if (!stop_bits_ok(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (!parity_ok(PARITY)) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic                 take;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_par;

  uart_tx_hold #(
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY)
  ) u_hold (
    .clk         (clk),
    .reset_pulse (reset_pulse),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .take        (take),
    .full        (hold_full),
    .hold_data   (hold_data),
    .hold_par    (hold_par)
  );

  // State and datapath registers; reset leaves the line idle high.
  always_ff @(posedge clk) begin
    if (reset_pulse) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Next state and next line level; nothing moves without a baud tick.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    take       = 1'b0;
    if (baud_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hold_full) begin
            take    = 1'b1;
            shift_d = hold_data;
            par_d   = hold_par;
            tx_d    = 1'b0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY == PAR_NONE) begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = ST_STOP;
            end else begin
              tx_d    = par_q;
              state_d = ST_PAR;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        ST_PAR: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            // A queued word starts immediately, so frames run back to back.
            if (hold_full) begin
              take    = 1'b1;
              shift_d = hold_data;
              par_d   = hold_par;
              tx_d    = 1'b0;
              state_d = ST_START;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            tx_d       = 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers; busy covers every non-idle state.
  always_comb begin
    tx_out     = tx_q;
    busy       = (state_q != ST_IDLE);
    frame_done = done_q;
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations share clock, reset and baud
// tick; a monitor records the line once per bit period and frames are
// compared with a bit list built from the frame format rules.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       reset_pulse;
  logic       baud_tick = 1'b0;
  logic [8:0] tb_data;
  logic       tb_valid;
  int         sel;
  int         tick_cnt = 0;

  logic in_valid_a, in_ready_a, tx_a, busy_a, done_a;
  logic in_valid_b, in_ready_b, tx_b, busy_b, done_b;
  logic in_valid_c, in_ready_c, tx_c, busy_c, done_c;

  int n_tests;
  int n_fail;
  int acc_cnt;

  logic exp_q[$];
  logic line_q[$];
  logic busy_q[$];
  int   fd_q[$];

  // Clock
  always #5 clk = ~clk;

  assign in_valid_a = tb_valid && (sel == 0);
  assign in_valid_b = tb_valid && (sel == 1);
  assign in_valid_c = tb_valid && (sel == 2);

  uart_tx_framer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_a (
    .clk(clk), .reset_pulse(reset_pulse), .baud_tick(baud_tick),
    .in_data(tb_data[7:0]), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .tx_out(tx_a), .busy(busy_a), .frame_done(done_a));

  uart_tx_framer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .reset_pulse(reset_pulse), .baud_tick(baud_tick),
    .in_data(tb_data[7:0]), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .tx_out(tx_b), .busy(busy_b), .frame_done(done_b));

  uart_tx_framer #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset_pulse(reset_pulse), .baud_tick(baud_tick),
    .in_data(tb_data[6:0]), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .tx_out(tx_c), .busy(busy_c), .frame_done(done_c));

  function automatic logic f_tx();
    case (sel) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
  endfunction
  function automatic logic f_busy();
    case (sel) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic f_rdy();
    case (sel) 0: return in_ready_a; 1: return in_ready_b; default: return in_ready_c; endcase
  endfunction
  function automatic logic f_done();
    case (sel) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction
  function automatic int cfg_dbits(input int s);
    return (s == 2) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int s);
    case (s) 0: return 2; 1: return 1; default: return 0; endcase
  endfunction
  function automatic int cfg_stops(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  // Baud tick every 4 clk plus a line monitor sampling each new bit period.
  always @(negedge clk) begin
    if (baud_tick) begin
      line_q.push_back(f_tx());
      busy_q.push_back(f_busy());
    end
    if (f_done()) fd_q.push_back(line_q.size() - 1);
    tick_cnt  = (tick_cnt + 1) % 4;
    baud_tick = (tick_cnt == 3);
  end

  // Accept counter for the selected configuration.
  always @(posedge clk) begin
    if (tb_valid && f_rdy()) acc_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input logic obs, input logic exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input int obs, input int exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    line_q.delete();
    busy_q.delete();
    fd_q.delete();
    exp_q.delete();
    acc_cnt = 0;
  endtask

  task automatic reset_all();
    tb_valid    = 1'b0;
    reset_pulse = 1'b1;
    step();
    step();
    reset_pulse = 1'b0;
    clear_mon();
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * 4) step();
  endtask

  // Reference frame: start 0, data LSB first, parity, stop 1s.
  task automatic push_frame(input int s, input logic [8:0] w);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_dbits(s); i++) begin
      exp_q.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (cfg_par(s) == 2) exp_q.push_back(ones % 2 == 1);
    if (cfg_par(s) == 1) exp_q.push_back(ones % 2 == 0);
    for (int i = 0; i < cfg_stops(s); i++) exp_q.push_back(1'b1);
  endtask

  // Present a word and leave in_valid high until the caller moves on.
  task automatic send(input logic [8:0] w, input string tag);
    int guard = 0;
    tb_data  = w;
    tb_valid = 1'b1;
    while (!f_rdy() && guard < 200) begin
      step();
      guard++;
    end
    check_bit(f_rdy(), 1'b1, {tag, "_ready_wait"});
    step();
    check_bit(f_rdy(), 1'b0, {tag, "_ready_drop"});
  endtask

  task automatic check_frames(input int nwords, input string tag);
    int k = -1;
    int len = exp_q.size();
    int flen = len / nwords;
    int zeros = 0;
    int busy_n = 0;
    logic obs;
    for (int i = 0; i < line_q.size(); i++) begin
      if (line_q[i] === 1'b0) begin
        k = i;
        break;
      end
    end
    check_bit(k >= 0, 1'b1, {tag, "_start_seen"});
    if (k < 0) k = 0;
    for (int i = 0; i < len; i++) begin
      obs = (k + i < line_q.size()) ? line_q[k + i] : 1'bx;
      check_bit(obs, exp_q[i], $sformatf("%s_bit%0d", tag, i));
    end
    for (int j = k + len; j < line_q.size(); j++) if (line_q[j] !== 1'b1) zeros++;
    check_int(zeros, 0, {tag, "_idle_after"});
    check_bit(line_q.size() > k + len, 1'b1, {tag, "_tail_seen"});
    foreach (busy_q[i]) if (busy_q[i] === 1'b1) busy_n++;
    check_int(busy_n, len, {tag, "_busy_periods"});
    check_int(fd_q.size(), nwords, {tag, "_done_count"});
    for (int j = 0; j < nwords && j < fd_q.size(); j++)
      check_int(fd_q[j], k + (j + 1) * flen, $sformatf("%s_done_pos%0d", tag, j));
    check_int(acc_cnt, nwords, {tag, "_accepts"});
  endtask

  initial begin
    int guard;
    int zeros;
    int busy_n;
    logic [8:0] w;
    n_tests     = 0;
    n_fail      = 0;
    acc_cnt     = 0;
    sel         = 0;
    tb_data     = '0;
    tb_valid    = 1'b0;
    reset_pulse = 1'b1;
    repeat (3) step();
    reset_pulse = 1'b0;
    step();

    // Reset values on all three configurations.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check_bit(f_tx(), 1'b1, $sformatf("rst_tx_%0d", s));
      check_bit(f_busy(), 1'b0, $sformatf("rst_busy_%0d", s));
      check_bit(f_rdy(), 1'b1, $sformatf("rst_ready_%0d", s));
      check_bit(f_done(), 1'b0, $sformatf("rst_done_%0d", s));
    end

    // 8E1, 0xA5.
    sel = 0;
    reset_all();
    push_frame(0, 9'h0A5);
    send(9'h0A5, "a5");
    tb_valid = 1'b0;
    wait_ticks(16);
    check_frames(1, "e8_a5");

    // 8O1, 0x00 gives parity 1.
    sel = 1;
    reset_all();
    push_frame(1, 9'h000);
    send(9'h000, "z0");
    tb_valid = 1'b0;
    wait_ticks(16);
    check_frames(1, "o8_00");

    // 7N2, 0x55 then 0x2A back to back with in_valid held.
    sel = 2;
    reset_all();
    push_frame(2, 9'h055);
    push_frame(2, 9'h02A);
    send(9'h055, "c55");
    send(9'h02A, "c2a");
    tb_valid = 1'b0;
    wait_ticks(26);
    check_frames(2, "n7_pair");

    // Four random words per configuration, in_valid held throughout.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      reset_all();
      for (int n = 0; n < 4; n++) begin
        w = 9'($urandom_range(0, (1 << cfg_dbits(s)) - 1));
        push_frame(s, w);
        send(w, $sformatf("rnd%0d_%0d", s, n));
      end
      tb_valid = 1'b0;
      wait_ticks(4 * 12 + 8);
      check_frames(4, $sformatf("rnd_cfg%0d", s));
    end

    // Reset during data bit 3 with a second word waiting.
    sel = 0;
    reset_all();
    send(9'h0C3, "rst_w1");
    send(9'h03C, "rst_w2");
    tb_valid = 1'b0;
    guard = 0;
    while (!f_busy() && guard < 40) begin
      step();
      guard++;
    end
    check_bit(f_busy(), 1'b1, "rst_frame_started");
    guard = 0;
    for (int n = 0; n < 4 && guard < 40; ) begin
      step();
      guard++;
      if (baud_tick) n++;
    end
    step();
    check_bit(f_busy(), 1'b1, "rst_mid_busy");
    check_bit(f_rdy(), 1'b0, "rst_mid_held");
    reset_pulse = 1'b1;
    step();
    reset_pulse = 1'b0;
    check_bit(f_tx(), 1'b1, "rst_mid_tx");
    check_bit(f_busy(), 1'b0, "rst_mid_busy_low");
    check_bit(f_rdy(), 1'b1, "rst_mid_ready");
    check_bit(f_done(), 1'b0, "rst_mid_done");
    clear_mon();
    wait_ticks(15);
    zeros = 0;
    busy_n = 0;
    foreach (line_q[i]) if (line_q[i] !== 1'b1) zeros++;
    foreach (busy_q[i]) if (busy_q[i] !== 1'b0) busy_n++;
    check_int(zeros, 0, "rst_after_line");
    check_int(busy_n, 0, "rst_after_busy");
    check_int(fd_q.size(), 0, "rst_after_done");

    // Ticks with no data leave the line idle.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      reset_all();
      wait_ticks(20);
      zeros = 0;
      busy_n = 0;
      foreach (line_q[i]) if (line_q[i] !== 1'b1) zeros++;
      foreach (busy_q[i]) if (busy_q[i] !== 1'b0) busy_n++;
      check_bit(line_q.size() >= 19, 1'b1, $sformatf("idle_ticks_%0d", s));
      check_int(zeros, 0, $sformatf("idle_line_%0d", s));
      check_int(busy_n, 0, $sformatf("idle_busy_%0d", s));
      check_int(fd_q.size(), 0, $sformatf("idle_done_%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer, the successor to the fixed 11-bit shift register in `uart_tx`. It accepts raw data words over a valid/ready handshake and builds each frame internally: start bit, 5–9 data bits LSB first, optional odd/even parity, and 1 or 2 stop bits. A one-entry holding register allows back-to-back frames with no idle gap. It sits between the byte source (FIFO or controller) and the `tx` pin, and is paced by the shared baud tick generator.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `clk` input, 1 bit: system clock; the only clock.
- `reset_pulse` input, 1 bit: synchronous, active-high reset.
- `baud_tick` input, 1 bit: one-`clk`-wide strobe, once per bit period.
- `in_data` input, `DATA_BITS` bits: word to transmit.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the holding register is empty.
- `tx_out` output, 1 bit: serial line, idle high, registered.
- `busy` output, 1 bit: a frame is on the line.
- `frame_done` output, 1 bit: one-`clk` pulse when the last stop bit ends.

## Operation
- Reset values: `tx_out`=1, `busy`=0, `in_ready`=1, `frame_done`=0, state IDLE, holding register empty.
- Accept: a word is accepted when `in_valid && in_ready` at a `clk` edge. The word is latched, the holding register becomes full, and `in_ready` drops the next cycle.
- Parity is computed on accept and stored with the word. Odd: the ones count of data+parity is odd. Even: that count is even.
- All line and state changes happen only on cycles with `baud_tick`=1. Each change is visible on `tx_out` the following cycle.
- State machine (encoding in package): IDLE, START, DATA, PAR, STOP.
  - IDLE: if `baud_tick` and the holding register is full, transfer the word to the shifter, empty the holding register, drive `tx_out`=0, go to START. `busy` rises with the start bit.
  - START, on tick: drive data bit 0, `bit_cnt`=0, go to DATA.
  - DATA, on tick: if `bit_cnt`=`DATA_BITS`-1, go to PAR (drive parity) or, when `PARITY`=0, go to STOP (drive 1). Otherwise shift, drive the next bit, increment `bit_cnt`.
  - PAR, on tick: drive 1, go to STOP with `stop_cnt`=0.
  - STOP, on tick: if `stop_cnt`=`STOP_BITS`-1, pulse `frame_done`. Then, if the holding register is full, do the IDLE transfer in this same cycle and go to START (no idle bit). Otherwise go to IDLE, `tx_out` stays 1, `busy` falls. If `stop_cnt`<`STOP_BITS`-1, increment `stop_cnt` and keep `tx_out` high.
- Holding-register transfer and a new accept never occur in the same cycle, because `in_ready` is still low on the transfer cycle.
- `in_valid` without `in_ready` has no effect. The source must hold `in_data` stable until accepted.
- Reset mid-frame: the next cycle `tx_out`=1, the holding register is emptied, state is IDLE, and no `frame_done` is produced. The partial frame is abandoned.
- A `baud_tick` in IDLE with the holding register empty has no effect.

## Timing
- Accept to start-bit start: from 1 cycle up to one bit period, depending on tick phase.
- Frame length is 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` bit periods, each period being tick-to-tick.
- `frame_done` is asserted in the cycle after the tick that ends the last stop bit.
- `in_ready` returns high one cycle after the holding-register transfer.

## Structure
- Package `uart_pkg`:
  - state enum;
  - parity mode constants NONE/ODD/EVEN;
  - `DATA_BITS`/`STOP_BITS` legality checks as elaboration-time assertions.
- Sub-module `uart_tx_hold`: one-entry valid/ready holding register that computes parity on accept. The FSM, shifter and counters stay in `uart_tx_framer`.
- Counters:
  - `bit_cnt`: $clog2(`DATA_BITS`) bits;
  - `stop_cnt`: 1 bit.

## Test plan
- `DATA_BITS`=8, `PARITY`=2, `STOP_BITS`=1, tick every 4 clk; send 0xA5 → `tx_out` bit periods 0,1,0,1,0,0,1,0,1,0,1; one `frame_done`; `busy` high for exactly 11 bit periods.
- Same config, `PARITY`=1, send 0x00 → parity bit 1; frame 0, eight 0s, 1, 1.
- `DATA_BITS`=7, `PARITY`=0, `STOP_BITS`=2, send 0x55 then 0x2A with `in_valid` held → frames 0,1010101,1,1 then 0,0101010,1,1. The second start bit follows the last stop bit directly; two `frame_done` pulses, 10 periods apart.
- `in_valid` held continuously → `in_ready` low while the holding register is full; exactly one accept per frame; no word lost or duplicated across 4 frames.
- Assert `reset_pulse` during data bit 3 with a word held → next cycle `tx_out`=1, `busy`=0, `in_ready`=1; no `frame_done`; line stays idle across the following ticks.
- Ticks arriving with no data for 20 periods → `tx_out` stays 1, `busy` stays 0.
